// File: rtl/mips_defs_pkg.sv
// Shared MIPS core definitions: datapath widths, load-type encodings, writeback FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mips_defs;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 5;

  // Load-type encodings carried on in_ld_op; 3'd7 is deliberately left undefined.
  typedef enum logic [2:0] {
    LD_LW  = 3'd0,
    LD_LB  = 3'd1,
    LD_LBU = 3'd2,
    LD_LH  = 3'd3,
    LD_LHU = 3'd4,
    LD_LWL = 3'd5,
    LD_LWR = 3'd6
  } ld_op_t;

  // Writeback FSM states.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_MEM = 2'd1,
    ST_WRITE    = 2'd2
  } wb_state_t;

endpackage

// File: rtl/load_align.sv
// Load data aligner: picks/extends the addressed byte or halfword, or merges LWL/LWR with old rt.
// Latency: purely combinational. Config macro LWLR_EN enables LWL/LWR; otherwise ops 5/6 are undefined.
// Backpressure: none; data_ok=0 flags an undefined load type so the caller suppresses the write.
module load_align
  import mips_defs::*;
(
  input  logic [2:0]  ld_op,
  input  logic [1:0]  k,
  input  logic [31:0] mem_rdata,
  input  logic [31:0] rt,
  output logic [31:0] data,
  output logic        data_ok
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Little-endian lane selection: byte k, halfword addr[1] (addr[0] ignored for halfwords).
  assign byte_sel = 8'(mem_rdata >> {k, 3'b000});
  assign half_sel = 16'(mem_rdata >> {k[1], 4'b0000});

`ifdef LWLR_EN
  logic [4:0] lwl_sh;
  logic [4:0] lwr_sh;

  // LWL shifts by 8*(3-k); for a 2-bit k, 3-k is simply ~k.
  assign lwl_sh = {~k, 3'b000};
  assign lwr_sh = {k, 3'b000};
`else
  logic unused_rt;
  assign unused_rt = ^rt;
`endif

  // Decode load type into aligned/extended register write data.
  always_comb begin
    data    = '0;
    data_ok = 1'b1;
    case (ld_op)
      LD_LW:  data = mem_rdata;
      LD_LB:  data = {{24{byte_sel[7]}}, byte_sel};
      LD_LBU: data = {24'h0, byte_sel};
      LD_LH:  data = {{16{half_sel[15]}}, half_sel};
      LD_LHU: data = {16'h0, half_sel};
`ifdef LWLR_EN
      LD_LWL: data = (mem_rdata << lwl_sh) | (rt & ~(32'hFFFF_FFFF << lwl_sh));
      LD_LWR: data = (mem_rdata >> lwr_sh) | (rt & ~(32'hFFFF_FFFF >> lwr_sh));
`endif
      default: data_ok = 1'b0;
    endcase
  end

endmodule

// File: rtl/load_writeback.sv
// Writeback stage: retires one instruction, waiting for load data if needed, then writes the reg file once.
// Latency: write 1 cycle after accept (non-load) or after mem_rvalid (load). Config macro LWLR_EN (see load_align).
// Backpressure: in_ready only in IDLE, mem_rready only in WAIT_MEM; all outputs registered (Moore).
module load_writeback
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_is_load,
  input  logic                  in_wb_en,
  input  logic [2:0]            in_ld_op,
  input  logic [ADDR_WIDTH-1:0] in_dest,
  input  logic [DATA_WIDTH-1:0] in_result,
  input  logic [DATA_WIDTH-1:0] in_rt,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_rvalid,
  output logic                  mem_rready,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  output logic                  wb_done
);

  import mips_defs::*;

  wb_state_t             state_q, state_d;
  logic                  capture;
  logic                  wb_en_q;
  logic [2:0]            ld_op_q;
  logic [ADDR_WIDTH-1:0] dest_q;
  logic [1:0]            k_q;
  logic [DATA_WIDTH-1:0] rt_q;

  logic                  wen_d;
  logic [ADDR_WIDTH-1:0] waddr_d;
  logic [DATA_WIDTH-1:0] wdata_d;
  logic                  done_d;

  logic [DATA_WIDTH-1:0] align_data;
  logic                  align_ok;

  load_align u_align (
    .ld_op     (ld_op_q),
    .k         (k_q),
    .mem_rdata (mem_rdata),
    .rt        (rt_q),
    .data      (align_data),
    .data_ok   (align_ok)
  );

  // State register; reset drops any captured instruction immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next state plus the write-port values to present while in WRITE.
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    wen_d   = 1'b0;
    waddr_d = '0;
    wdata_d = '0;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          capture = 1'b1;
          if (in_is_load) begin
            state_d = ST_WAIT_MEM;
          end else begin
            state_d = ST_WRITE;
            wen_d   = in_wb_en && (in_dest != '0);
            waddr_d = in_dest;
            wdata_d = in_result;
            done_d  = 1'b1;
          end
        end
      end
      ST_WAIT_MEM: begin
        if (mem_rvalid) begin
          state_d = ST_WRITE;
          wen_d   = wb_en_q && (dest_q != '0) && align_ok;
          waddr_d = dest_q;
          wdata_d = align_data;
          done_d  = 1'b1;
        end
      end
      ST_WRITE: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Hold the retiring instruction's fields while waiting for load data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_en_q <= 1'b0;
      ld_op_q <= '0;
      dest_q  <= '0;
      k_q     <= '0;
      rt_q    <= '0;
    end else if (capture) begin
      wb_en_q <= in_wb_en;
      ld_op_q <= in_ld_op;
      dest_q  <= in_dest;
      k_q     <= in_result[1:0];
      rt_q    <= in_rt;
    end
  end

  // Registered outputs so every handshake/write signal is a clean Moore output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_wen     <= 1'b0;
      rf_waddr   <= '0;
      rf_wdata   <= '0;
      wb_done    <= 1'b0;
      in_ready   <= 1'b1;
      mem_rready <= 1'b0;
    end else begin
      rf_wen     <= wen_d;
      rf_waddr   <= waddr_d;
      rf_wdata   <= wdata_d;
      wb_done    <= done_d;
      in_ready   <= (state_d == ST_IDLE);
      mem_rready <= (state_d == ST_WAIT_MEM);
    end
  end

endmodule

// File: tb/tb_load_writeback.sv
// Scoreboarded bench for load_writeback: expected writes queued at issue, checked on each wb_done pulse.
// Latency: checks write appears 1 cycle after accept / mem_rvalid.
// Backpressure: waits on in_ready with a bounded loop; LWL/LWR expectations follow LWLR_EN.
module tb_load_writeback;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_is_load, in_wb_en;
  logic [2:0]  in_ld_op;
  logic [4:0]  in_dest;
  logic [31:0] in_result, in_rt, mem_rdata;
  logic        mem_rvalid, mem_rready;
  logic        rf_wen, wb_done;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  typedef struct packed {
    logic        wen;
    logic [4:0]  addr;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  logic prev_done = 1'b0;

  load_writeback dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_is_load (in_is_load),
    .in_wb_en   (in_wb_en),
    .in_ld_op   (in_ld_op),
    .in_dest    (in_dest),
    .in_result  (in_result),
    .in_rt      (in_rt),
    .mem_rdata  (mem_rdata),
    .mem_rvalid (mem_rvalid),
    .mem_rready (mem_rready),
    .rf_wen     (rf_wen),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .wb_done    (wb_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Reference aligner written byte-wise, independent of shift/mask formulation.
  function automatic logic [32:0] ref_align(input logic [2:0] op, input logic [1:0] k,
                                            input logic [31:0] mem, input logic [31:0] rt);
    logic [7:0]  mb [4];
    logic [7:0]  rb [4];
    logic [31:0] r;
    logic        ok;
    int          h;
    for (int i = 0; i < 4; i++) begin
      mb[i] = mem[8*i +: 8];
      rb[i] = rt[8*i +: 8];
    end
    h  = k[1] ? 2 : 0;
    ok = 1'b1;
    r  = 32'h0;
    case (op)
      3'd0: r = mem;
      3'd1: r = {{24{mb[k][7]}}, mb[k]};
      3'd2: r = {24'h0, mb[k]};
      3'd3: r = {{16{mb[h+1][7]}}, mb[h+1], mb[h]};
      3'd4: r = {16'h0, mb[h+1], mb[h]};
`ifdef LWLR_EN
      3'd5: for (int i = 0; i < 4; i++) r[8*i +: 8] = (i >= 3 - int'(k)) ? mb[i - (3 - int'(k))] : rb[i];
      3'd6: for (int i = 0; i < 4; i++) r[8*i +: 8] = (i <= 3 - int'(k)) ? mb[i + int'(k)] : rb[i];
`endif
      default: ok = 1'b0;
    endcase
    return {ok, r};
  endfunction

  // Monitor: every wb_done pulse retires one scoreboard entry; rf_wen never appears alone.
  always @(negedge clk) begin
    if (!rst) begin
      if (rf_wen && !wb_done) chk("wen_without_done", 32'(rf_wen), 32'd0);
      if (wb_done) begin
        chk("done_one_cycle", 32'(prev_done), 32'd0);
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 32'(wb_done), 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("rf_wen", 32'(rf_wen), 32'(e.wen));
          if (e.wen) begin
            chk("rf_waddr", 32'(rf_waddr), 32'(e.addr));
            chk("rf_wdata", rf_wdata, e.data);
          end
        end
      end
      prev_done = wb_done;
    end else begin
      prev_done = 1'b0;
    end
  end

  task automatic issue(input logic ld, input logic we, input logic [2:0] op, input logic [4:0] dst,
                       input logic [31:0] res, input logic [31:0] rt, input logic [31:0] mem,
                       input logic ew, input logic [31:0] ed);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_wait", 32'(in_ready), 32'd1);
    exp_q.push_back(exp_t'{ew, dst, ed});
    in_valid   = 1'b1;
    in_is_load = ld;
    in_wb_en   = we;
    in_ld_op   = op;
    in_dest    = dst;
    in_result  = res;
    in_rt      = rt;
    @(negedge clk);
    in_valid  = 1'b0;
    in_result = $urandom;
    in_rt     = $urandom;
    if (ld) begin
      chk("mem_rready", 32'(mem_rready), 32'd1);
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        chk("early_done", 32'(wb_done), 32'd0);
      end
      mem_rdata  = mem;
      mem_rvalid = 1'b1;
      @(negedge clk);
      mem_rvalid = 1'b0;
      mem_rdata  = $urandom;
      chk("load_latency", 32'(wb_done), 32'd1);
    end else begin
      chk("nonload_latency", 32'(wb_done), 32'd1);
    end
    @(negedge clk);
    chk("in_ready_after", 32'(in_ready), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [32:0] m;
    logic [2:0]  op;
    logic [1:0]  k;
    logic [31:0] mem, rt;

    rst = 1'b1;
    in_valid = 1'b0; in_is_load = 1'b0; in_wb_en = 1'b0; in_ld_op = 3'd0;
    in_dest = 5'd0; in_result = 32'h0; in_rt = 32'h0;
    mem_rdata = 32'h0; mem_rvalid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_rf_wen", 32'(rf_wen), 32'd0);
    chk("rst_rf_waddr", 32'(rf_waddr), 32'd0);
    chk("rst_rf_wdata", rf_wdata, 32'd0);
    chk("rst_wb_done", 32'(wb_done), 32'd0);
    chk("rst_mem_rready", 32'(mem_rready), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;
    @(negedge clk);

    // Non-load write.
    issue(1'b0, 1'b1, 3'd0, 5'd8, 32'h1234_5678, 32'h0, 32'h0, 1'b1, 32'h1234_5678);

    // mem_rvalid while idle must do nothing.
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hDEAD_BEEF;
    repeat (3) begin
      @(negedge clk);
      chk("idle_rvalid_done", 32'(wb_done), 32'd0);
      chk("idle_rvalid_ready", 32'(in_ready), 32'd1);
    end
    mem_rvalid = 1'b0;

    // Byte / halfword / word loads.
    issue(1'b1, 1'b1, 3'd1, 5'd9,  32'h1000_0003, 32'h0, 32'h80FF_0000, 1'b1, 32'hFFFF_FF80);
    issue(1'b1, 1'b1, 3'd2, 5'd10, 32'h1000_0003, 32'h0, 32'h80FF_0000, 1'b1, 32'h0000_0080);
    issue(1'b1, 1'b1, 3'd3, 5'd11, 32'h1000_0002, 32'h0, 32'h8001_1234, 1'b1, 32'hFFFF_8001);
    issue(1'b1, 1'b1, 3'd4, 5'd12, 32'h1000_0002, 32'h0, 32'h8001_1234, 1'b1, 32'h0000_8001);
    issue(1'b1, 1'b1, 3'd0, 5'd13, 32'h1000_0002, 32'h0, 32'h8001_1234, 1'b1, 32'h8001_1234);
    // LH with addr[0] set: addr[0] ignored, no trap.
    issue(1'b1, 1'b1, 3'd3, 5'd14, 32'h1000_0001, 32'h0, 32'h8001_1234, 1'b1, 32'h0000_1234);

    // Unaligned word merges.
`ifdef LWLR_EN
    issue(1'b1, 1'b1, 3'd5, 5'd15, 32'h1000_0001, 32'h1122_3344, 32'hAABB_CCDD, 1'b1, 32'hCCDD_3344);
    issue(1'b1, 1'b1, 3'd6, 5'd16, 32'h1000_0001, 32'h1122_3344, 32'hAABB_CCDD, 1'b1, 32'h11AA_BBCC);
`else
    issue(1'b1, 1'b1, 3'd5, 5'd15, 32'h1000_0001, 32'h1122_3344, 32'hAABB_CCDD, 1'b0, 32'h0);
    issue(1'b1, 1'b1, 3'd6, 5'd16, 32'h1000_0001, 32'h1122_3344, 32'hAABB_CCDD, 1'b0, 32'h0);
`endif
    // Undefined load type.
    issue(1'b1, 1'b1, 3'd7, 5'd17, 32'h1000_0000, 32'h0, 32'h5555_AAAA, 1'b0, 32'h0);

    // Suppressed writes: dest 0, wb_en 0.
    issue(1'b0, 1'b1, 3'd0, 5'd0, 32'hCAFE_F00D, 32'h0, 32'h0, 1'b0, 32'h0);
    issue(1'b0, 1'b0, 3'd0, 5'd5, 32'hCAFE_F00D, 32'h0, 32'h0, 1'b0, 32'h0);
    issue(1'b1, 1'b1, 3'd0, 5'd0, 32'h1000_0000, 32'h0, 32'h0BAD_0BAD, 1'b0, 32'h0);
    issue(1'b1, 1'b0, 3'd0, 5'd6, 32'h1000_0000, 32'h0, 32'h0BAD_0BAD, 1'b0, 32'h0);

    // Randomised loads against the byte-wise reference.
    for (int i = 0; i < 16; i++) begin
      op  = 3'($urandom_range(0, 7));
      k   = 2'($urandom);
      mem = $urandom;
      rt  = $urandom;
      m   = ref_align(op, k, mem, rt);
      issue(1'b1, 1'b1, op, 5'd20, {30'h0400_0000, k}, rt, mem, m[32], m[31:0]);
    end

    // Reset while waiting for memory discards the instruction.
    in_valid = 1'b1; in_is_load = 1'b1; in_wb_en = 1'b1; in_ld_op = 3'd0;
    in_dest = 5'd21; in_result = 32'h1000_0000;
    @(negedge clk);
    in_valid = 1'b0;
    chk("pre_rst_mem_rready", 32'(mem_rready), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_rf_wen", 32'(rf_wen), 32'd0);
    chk("midrst_wb_done", 32'(wb_done), 32'd0);
    chk("midrst_mem_rready", 32'(mem_rready), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    mem_rdata  = 32'h7777_7777;
    mem_rvalid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_done", 32'(wb_done), 32'd0);
      chk("post_rst_wen", 32'(rf_wen), 32'd0);
    end
    mem_rvalid = 1'b0;

    // Stage still works after the abort.
    issue(1'b0, 1'b1, 3'd0, 5'd31, 32'hA5A5_5A5A, 32'h0, 32'h0, 1'b1, 32'hA5A5_5A5A);

    repeat (2) @(negedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
